// File: rtl/fetch_stall_unit.sv
// fetch_stall_unit
// Register-side half of the load-use hazard handshake. Owns the fetch PC, the IF/ID pipeline
// register and the ID/EX control-bubble register, and keeps saturating stall/flush counters.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-low reset
//   PCWrite            - 1 = PC may advance by 4
//   IFID_Write         - 1 = IF/ID may load {pc_out, instr_in}
//   IDEX_mux_out       - 0 = insert a bubble into ID/EX control
//   branch_taken       - EX-stage redirect; flushes IF/ID and ID/EX, overrides the enables
//   branch_target      - redirect address
//   instr_in           - instruction memory data for the current pc_out
//   id_ctrl_in         - decoded control for the instruction held in IF/ID
//   perf_clear         - synchronous clear of both counters (beats increment)
//   pc_out             - current fetch PC
//   IFID_pc/_instr/_valid - IF/ID contents
//   IDEX_ctrl/_valid   - control bundle and valid into EX
//   stall_count        - hazard bubble cycles (not counted when a branch coincides)
//   flush_count        - taken-branch flush cycles
module fetch_stall_unit #(
  parameter int unsigned    XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    CTRL_W   = 8,
  parameter int unsigned    CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              IFID_Write,
  input  logic              IDEX_mux_out,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] id_ctrl_in,
  input  logic              perf_clear,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   IFID_pc,
  output logic [31:0]       IFID_instr,
  output logic              IFID_valid,
  output logic [CTRL_W-1:0] IDEX_ctrl,
  output logic              IDEX_valid,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [31:0]      Nop    = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
  logic              idex_valid_q, idex_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic bubble;
  logic stall_evt;

  always_comb begin
    // PC: redirect beats the hazard hold; increment wraps naturally modulo 2^XLEN.
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = branch_target;
    end else if (PCWrite) begin
      pc_d = pc_q + XLEN'(4);
    end

    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (branch_taken) begin
      ifid_pc_d    = '0;
      ifid_instr_d = Nop;
      ifid_valid_d = 1'b0;
    end else if (IFID_Write) begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = instr_in;
      ifid_valid_d = 1'b1;
    end

    // An empty IF/ID slot must not launch its stale decode into EX.
    bubble       = branch_taken || !IDEX_mux_out || !ifid_valid_q;
    idex_ctrl_d  = bubble ? '0 : id_ctrl_in;
    idex_valid_d = !bubble;

    // A stall hidden under a flush is charged to the flush only.
    stall_evt   = !IDEX_mux_out && !branch_taken;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_evt && (stall_cnt_q != CntMax)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (branch_taken && (flush_cnt_q != CntMax)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= Nop;
      ifid_valid_q <= 1'b0;
      idex_ctrl_q  <= '0;
      idex_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_valid_q <= idex_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign pc_out      = pc_q;
  assign IFID_pc     = ifid_pc_q;
  assign IFID_instr  = ifid_instr_q;
  assign IFID_valid  = ifid_valid_q;
  assign IDEX_ctrl   = idex_ctrl_q;
  assign IDEX_valid  = idex_valid_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stall_unit.sv
module tb_fetch_stall_unit;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          CMAX   = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              PCWrite, IFID_Write, IDEX_mux_out, branch_taken, perf_clear;
  logic [XLEN-1:0]   branch_target;
  logic [31:0]       instr_in;
  logic [CTRL_W-1:0] id_ctrl_in;
  logic [XLEN-1:0]   pc_out, IFID_pc;
  logic [31:0]       IFID_instr;
  logic              IFID_valid, IDEX_valid;
  logic [CTRL_W-1:0] IDEX_ctrl;
  logic [CNT_W-1:0]  stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stall_unit #(
    .XLEN(XLEN), .RESET_PC('0), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .IDEX_mux_out(IDEX_mux_out), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_in(instr_in), .id_ctrl_in(id_ctrl_in), .perf_clear(perf_clear),
    .pc_out(pc_out), .IFID_pc(IFID_pc), .IFID_instr(IFID_instr), .IFID_valid(IFID_valid),
    .IDEX_ctrl(IDEX_ctrl), .IDEX_valid(IDEX_valid), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Instruction memory image: deterministic content per address.
  function automatic logic [31:0] imem(input logic [XLEN-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A00_0013;
  endfunction

  assign instr_in = imem(pc_out);

  // Reference model state (architectural view of the pipeline front end).
  logic [XLEN-1:0]   m_pc, m_ifpc;
  logic [31:0]       m_ifinstr;
  bit                m_ifv, m_idv;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_stall, m_flush;

  task automatic m_reset();
    m_pc = '0; m_ifpc = '0; m_ifinstr = 32'h13; m_ifv = 0;
    m_ctrl = '0; m_idv = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic set_in(input bit pcw, input bit ifw, input bit mux, input bit br,
                        input logic [XLEN-1:0] tgt, input bit clr);
    PCWrite = pcw; IFID_Write = ifw; IDEX_mux_out = mux; branch_taken = br;
    branch_target = tgt; perf_clear = clr;
  endtask

  // Advance model by one edge from the current inputs, then let the DUT take the edge.
  task automatic tick();
    logic [XLEN-1:0] npc;
    npc = branch_taken ? branch_target : (PCWrite ? m_pc + 64'd4 : m_pc);
    if (branch_taken || !IDEX_mux_out || !m_ifv) begin
      m_ctrl = '0; m_idv = 0;
    end else begin
      m_ctrl = id_ctrl_in; m_idv = 1;
    end
    if (branch_taken) begin
      m_ifpc = '0; m_ifinstr = 32'h13; m_ifv = 0;
    end else if (IFID_Write) begin
      m_ifpc = m_pc; m_ifinstr = imem(m_pc); m_ifv = 1;
    end
    if (perf_clear) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!IDEX_mux_out && !branch_taken) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
      if (branch_taken) m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
    end
    m_pc = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 0, '0, 0);
    id_ctrl_in = 8'h11;
    reset = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pc_out !== 64'd0 || IFID_pc !== 64'd0 || IFID_instr !== 32'h13 || IFID_valid !== 1'b0 ||
        IDEX_ctrl !== 8'd0 || IDEX_valid !== 1'b0 || stall_count !== 4'd0 ||
        flush_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h ifpc=%h ifi=%h ifv=%b ctrl=%h idv=%b st=%0d fl=%0d",
               pc_out, IFID_pc, IFID_instr, IFID_valid, IDEX_ctrl, IDEX_valid,
               stall_count, flush_count);
    end
    reset = 1;
  endtask

  task automatic test_free_run();
    tick();
    tick();
    n_checks++;
    if (IDEX_valid !== 1'b1 || IDEX_ctrl !== 8'h11) begin
      n_fail++;
      $display("FAIL free_run_idex_edge2: valid=%b ctrl=%h required 1/11", IDEX_valid, IDEX_ctrl);
    end
    tick();
    n_checks++;
    if (pc_out !== 64'hC || IFID_pc !== 64'h8 || IFID_valid !== 1'b1 ||
        IFID_instr !== imem(64'h8)) begin
      n_fail++;
      $display("FAIL free_run_edge3: pc=%h ifpc=%h ifv=%b required c/8/1", pc_out, IFID_pc,
               IFID_valid);
    end
  endtask

  task automatic test_load_use();
    logic [XLEN-1:0] ifpc0;
    tick();  // pc now 0x10
    ifpc0 = IFID_pc;
    set_in(0, 0, 0, 0, '0, 0);
    tick();
    n_checks++;
    if (pc_out !== 64'h10 || IFID_pc !== 64'hC || IDEX_valid !== 1'b0 || IDEX_ctrl !== 8'd0 ||
        stall_count !== 4'd1) begin
      n_fail++;
      $display("FAIL load_use_stall: pc=%h ifpc=%h idv=%b ctrl=%h st=%0d required 10/c/0/0/1",
               pc_out, IFID_pc, IDEX_valid, IDEX_ctrl, stall_count);
    end
    n_checks++;
    if (IFID_pc !== ifpc0) begin
      n_fail++;
      $display("FAIL load_use_ifid_hold: ifpc=%h required %h", IFID_pc, ifpc0);
    end
    set_in(1, 1, 1, 0, '0, 0);
    tick();
    n_checks++;
    if (pc_out !== 64'h14 || IDEX_valid !== 1'b1 || stall_count !== 4'd1) begin
      n_fail++;
      $display("FAIL load_use_resume: pc=%h idv=%b st=%0d required 14/1/1", pc_out, IDEX_valid,
               stall_count);
    end
  endtask

  task automatic test_branch_over_stall();
    set_in(0, 1, 0, 1, 64'h200, 0);
    tick();
    n_checks++;
    if (pc_out !== 64'h200 || IFID_instr !== 32'h13 || IFID_valid !== 1'b0 ||
        IDEX_valid !== 1'b0 || flush_count !== 4'd1 || stall_count !== 4'd1) begin
      n_fail++;
      $display("FAIL branch_over_stall: pc=%h ifi=%h ifv=%b idv=%b fl=%0d st=%0d req 200/13/0/0/1/1",
               pc_out, IFID_instr, IFID_valid, IDEX_valid, flush_count, stall_count);
    end
    // IF/ID empty: even with mux=1 the next EX slot must be a bubble.
    set_in(1, 1, 1, 0, '0, 0);
    tick();
    n_checks++;
    if (IDEX_valid !== 1'b0 || IFID_pc !== 64'h200 || pc_out !== 64'h204) begin
      n_fail++;
      $display("FAIL after_flush: idv=%b ifpc=%h pc=%h required 0/200/204", IDEX_valid, IFID_pc,
               pc_out);
    end
  endtask

  task automatic test_wrap_and_saturation();
    set_in(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    tick();
    set_in(1, 1, 1, 0, '0, 0);
    tick();
    n_checks++;
    if (pc_out !== 64'd0 || IFID_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h ifpc=%h required 0/fffffffffffffffc", pc_out, IFID_pc);
    end
    set_in(0, 0, 0, 0, '0, 1);
    tick();
    set_in(0, 0, 0, 0, '0, 0);
    repeat (20) tick();
    n_checks++;
    if (stall_count !== 4'd15) begin
      n_fail++;
      $display("FAIL stall_saturate: stall_count=%0d required 15", stall_count);
    end
    set_in(0, 0, 0, 0, '0, 1);
    tick();
    n_checks++;
    if (stall_count !== 4'd0 || flush_count !== 4'd0) begin
      n_fail++;
      $display("FAIL perf_clear_vs_stall: st=%0d fl=%0d required 0/0", stall_count, flush_count);
    end
    set_in(0, 0, 1, 1, 64'h40, 0);
    repeat (18) tick();
    n_checks++;
    if (flush_count !== 4'd15 || stall_count !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_saturate: fl=%0d st=%0d required 15/0", flush_count, stall_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) == 0, {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC},
             $urandom_range(0, 39) == 0);
      id_ctrl_in = 8'($urandom);
      tick();
      n_checks++;
      if (pc_out !== m_pc || IFID_pc !== m_ifpc || IFID_instr !== m_ifinstr ||
          IFID_valid !== m_ifv || IDEX_ctrl !== m_ctrl || IDEX_valid !== m_idv ||
          stall_count !== 4'(m_stall) || flush_count !== 4'(m_flush)) begin
        n_fail++;
        $display("FAIL random_step %0d: pc=%h/%h ifpc=%h/%h ifi=%h/%h ifv=%b/%b ctrl=%h/%h idv=%b/%b st=%0d/%0d fl=%0d/%0d",
                 i, pc_out, m_pc, IFID_pc, m_ifpc, IFID_instr, m_ifinstr, IFID_valid, m_ifv,
                 IDEX_ctrl, m_ctrl, IDEX_valid, m_idv, stall_count, m_stall, flush_count,
                 m_flush);
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(1, 1, 1, 0, '0, 0);
    id_ctrl_in = 8'h5C;
    repeat (3) tick();
    n_checks++;
    if (IDEX_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_precond: idv=%b required 1", IDEX_valid);
    end
    #2;
    reset = 0;
    m_reset();
    #1;
    n_checks++;
    if (pc_out !== 64'd0 || IFID_pc !== 64'd0 || IFID_instr !== 32'h13 || IFID_valid !== 1'b0 ||
        IDEX_ctrl !== 8'd0 || IDEX_valid !== 1'b0 || stall_count !== 4'd0 ||
        flush_count !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h ifpc=%h ifi=%h ifv=%b ctrl=%h idv=%b st=%0d fl=%0d",
               pc_out, IFID_pc, IFID_instr, IFID_valid, IDEX_ctrl, IDEX_valid,
               stall_count, flush_count);
    end
    @(posedge clk);
    #1;
    reset = 1;
    tick();
    n_checks++;
    if (pc_out !== 64'h4 || IFID_pc !== 64'd0 || IFID_valid !== 1'b1 ||
        IFID_instr !== imem(64'd0)) begin
      n_fail++;
      $display("FAIL post_reset_fetch: pc=%h ifpc=%h ifv=%b required 4/0/1", pc_out, IFID_pc,
               IFID_valid);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_use();
    test_branch_over_stall();
    test_wrap_and_saturation();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stall_unit.md
# fetch_stall_unit

- Register-side consumer of the load-use hazard handshake.
- Owns the PC register, the IF/ID pipeline register and the ID/EX control-bubble register.
- Applies `PCWrite`, `IFID_Write` and `IDEX_mux_out` from the hazard detector, and the EX-stage taken-branch flush.
- Keeps saturating stall/flush performance counters.
- Sits between instruction memory/decoder and the ID/EX datapath register.

## Interface

Parameters:
- `XLEN`, 64: PC width.
- `RESET_PC`, 0: PC value after reset.
- `CTRL_W`, 8: width of decoded control bundle.
- `CNT_W`, 32: performance counter width.

Ports:
- `clk`: input, 1. Single clock, rising edge.
- `reset`: input, 1. Asynchronous, active-low.
- `PCWrite`: input, 1. 1 = PC may advance.
- `IFID_Write`: input, 1. 1 = IF/ID may load.
- `IDEX_mux_out`: input, 1. 0 = insert bubble into ID/EX control.
- `branch_taken`: input, 1. EX-stage redirect/flush request.
- `branch_target`: input, XLEN. Redirect address.
- `instr_in`: input, 32. Instruction memory data for current `pc_out`.
- `id_ctrl_in`: input, CTRL_W. Decoder control for the instruction in IF/ID.
- `perf_clear`: input, 1. Synchronous clear of both counters.
- `pc_out`: output, XLEN. Current fetch PC.
- `IFID_pc`: output, XLEN. PC of the instruction in IF/ID.
- `IFID_instr`: output, 32. Instruction in IF/ID.
- `IFID_valid`: output, 1. IF/ID holds a real instruction.
- `IDEX_ctrl`: output, CTRL_W. Control bundle into EX.
- `IDEX_valid`: output, 1. EX holds a real instruction.
- `stall_count`: output, CNT_W. Bubble cycles inserted by the hazard path.
- `flush_count`: output, CNT_W. Taken-branch flush cycles.

## Operation

- Reset (`reset` = 0, asynchronous):
  - `pc_out` = RESET_PC.
  - `IFID_pc` = 0, `IFID_instr` = 32'h00000013 (NOP), `IFID_valid` = 0.
  - `IDEX_ctrl` = 0, `IDEX_valid` = 0.
  - Both counters = 0.
- PC register, priority order:
  1. `branch_taken` → `branch_target`. Overrides `PCWrite` = 0.
  2. `PCWrite` → `pc_out` + 4, modulo 2^XLEN. All-ones minus 3 wraps to 0.
  3. Otherwise hold.
- IF/ID register, priority order:
  1. `branch_taken` → `IFID_instr` = NOP, `IFID_pc` = 0, `IFID_valid` = 0.
  2. `IFID_Write` → load `pc_out`, `instr_in`; `IFID_valid` = 1.
  3. Otherwise hold all three fields.
- ID/EX control:
  - Bubble (`IDEX_ctrl` = 0, `IDEX_valid` = 0) when any of:
    - `branch_taken` = 1;
    - `IDEX_mux_out` = 0;
    - `IFID_valid` = 0.
  - Otherwise `IDEX_ctrl` = `id_ctrl_in`, `IDEX_valid` = 1.
- The three hazard enables are honoured independently. There is no consistency check; e.g. `PCWrite` = 0 with `IFID_Write` = 1 reloads IF/ID from the held PC.
- `stall_count`:
  - +1 on each cycle with `IDEX_mux_out` = 0 and `branch_taken` = 0.
  - A stall coincident with a branch is not counted.
- `flush_count`: +1 on each cycle with `branch_taken` = 1.
- Counters saturate at 2^CNT_W−1; no wrap.
- `perf_clear` beats increment: the counter becomes 0 that edge.

## Timing

- All outputs registered; each update takes effect at the next rising edge (latency 1).
- `instr_in` must be valid combinationally for the current `pc_out` within the same cycle.
- One load-use stall (hazard enables low for one cycle) gives:
  - PC and IF/ID held for exactly 1 edge;
  - exactly one `IDEX_valid` = 0 cycle.
- Reset asserted mid-stall or mid-flush forces reset values immediately, without waiting for an edge. The first edge after deassertion fetches from RESET_PC normally.
- Reset deassertion is synchronised externally.

## Test plan

- **Reset then free run** (`PCWrite` = `IFID_Write` = `IDEX_mux_out` = 1, RESET_PC = 0): after 3 edges `pc_out` = 0xC, `IFID_pc` = 0x8, `IFID_valid` = 1; `IDEX_valid` goes 1 on edge 2.
- **Load-use stall**: drive all three enables low for 1 cycle with `pc_out` = 0x10.
  - PC stays 0x10 and IF/ID is unchanged for 1 edge.
  - `IDEX_ctrl` = 0 and `IDEX_valid` = 0 for 1 cycle.
  - `stall_count` = 1.
- **Branch over stall**: `branch_taken` = 1, `branch_target` = 0x200, `PCWrite` = 0, `IDEX_mux_out` = 0.
  - Next edge: `pc_out` = 0x200, `IFID_instr` = 0x13, both valids = 0.
  - `flush_count` = 1, `stall_count` unchanged.
- **Wrap and saturation**: `pc_out` = 2^64−4 advances to 0. With CNT_W = 4, 20 stall cycles leave `stall_count` = 15. `perf_clear` coincident with a stall gives 0.
- **Async reset mid-operation**: assert `reset` = 0 between edges while `IDEX_valid` = 1. All outputs take reset values before the next edge.
